// File: rtl/cheri_tbre_sweep.sv
// Tag-bit revocation engine sweep: walks 8-byte granules, loads each one and
// writes it back untagged when the revocation checker asks for the tag to be cleared.
package cheri_tbre_pkg;
  typedef struct packed {
    logic        valid;
    logic [2:0]  otype;
    logic [12:0] perms;
    logic [4:0]  exp;
    logic [8:0]  top;
    logic [8:0]  base;
  } reg_cap_t;

  localparam reg_cap_t NULL_REG_CAP = '0;
endpackage

module cheri_tbre_sweep
  import cheri_tbre_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ctrl_start_i,
  input  logic        ctrl_stop_i,
  input  logic [31:0] ctrl_start_addr_i,
  input  logic [31:0] ctrl_end_addr_i,
  output logic        stat_busy_o,
  output logic        stat_done_o,
  output logic        stat_err_o,
  output logic [15:0] stat_clr_cnt_o,
  output logic        tbre_lsu_req_o,
  output logic        tbre_lsu_we_o,
  output logic [31:0] tbre_lsu_addr_o,
  output logic [31:0] tbre_lsu_wdata_o,
  output reg_cap_t    tbre_lsu_wcap_o,
  input  logic        lsu_tbre_gnt_i,
  input  logic        lsu_tbre_resp_valid_i,
  input  logic        lsu_tbre_resp_err_i,
  input  logic        lsu_resp_is_wr_i,
  input  logic [31:0] lsu_rdata_i,
  input  reg_cap_t    lsu_rcap_i,
  input  logic        tbre_trvk_en_i,
  input  logic        tbre_trvk_clrtag_i
);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, CHK_WAIT, ST_REQ, ST_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [32:0] end_q, end_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  tmo_q, tmo_d;
  logic        pend_q, pend_d;
  logic        ld_err_q, ld_err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  reg_cap_t    wcap_q, wcap_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [31:0] start_al, end_al;
  logic [32:0] next_addr;
  logic        do_adv, finish;

  assign start_al  = ctrl_start_addr_i & ~32'h7;
  assign end_al    = ctrl_end_addr_i & ~32'h7;
  assign next_addr = {1'b0, cur_q} + 33'd8;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pend_d   = pend_q;
    ld_err_d = ld_err_q;
    wdata_d  = wdata_q;
    wcap_d   = wcap_q;
    done_d   = 1'b0;
    do_adv   = 1'b0;
    finish   = 1'b0;

    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (ctrl_start_i) begin
          cur_d = start_al;
          // An end of 0 means the top of the address space, so a sweep can
          // reach the last granule and terminate on wrap.
          end_d = (end_al == '0) ? 33'h1_0000_0000 : {1'b0, end_al};
          err_d = 1'b0;
          cnt_d = '0;
          if ({1'b0, start_al} < end_d) state_d = LD_REQ;
          else                          done_d  = 1'b1;
        end
      end
      LD_REQ, ST_REQ: begin
        if (lsu_tbre_gnt_i) begin
          state_d = (state_q == LD_REQ) ? LD_WAIT : ST_WAIT;
          pend_d  = ctrl_stop_i;
        end else if (ctrl_stop_i) begin
          finish = 1'b1;
        end
      end
      LD_WAIT: begin
        if (ctrl_stop_i) pend_d = 1'b1;
        if (lsu_tbre_resp_valid_i && !lsu_resp_is_wr_i) begin
          wdata_d       = lsu_rdata_i;
          wcap_d        = lsu_rcap_i;
          wcap_d.valid  = 1'b0;
          ld_err_d      = lsu_tbre_resp_err_i;
          if (lsu_tbre_resp_err_i) err_d = 1'b1;
          tmo_d = '0;
          if (pend_q || ctrl_stop_i) finish  = 1'b1;
          else                       state_d = CHK_WAIT;
        end
      end
      CHK_WAIT: begin
        if (ctrl_stop_i) begin
          finish = 1'b1;
        end else if (tbre_trvk_en_i) begin
          if (tbre_trvk_clrtag_i && !ld_err_q) state_d = ST_REQ;
          else                                 do_adv  = 1'b1;
        end else if (tmo_q == 3'd5) begin
          err_d  = 1'b1;
          do_adv = 1'b1;
        end else begin
          tmo_d = tmo_q + 3'd1;
        end
      end
      ST_WAIT: begin
        if (ctrl_stop_i) pend_d = 1'b1;
        if (lsu_tbre_resp_valid_i && lsu_resp_is_wr_i) begin
          if (lsu_tbre_resp_err_i) err_d = 1'b1;
          else if (cnt_q != '1)    cnt_d = cnt_q + 16'd1;
          if (pend_q || ctrl_stop_i) finish = 1'b1;
          else                       do_adv = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_adv) begin
      cur_d = next_addr[31:0];
      if (next_addr >= end_q) finish  = 1'b1;
      else                    state_d = LD_REQ;
    end
    if (finish) begin
      state_d = IDLE;
      done_d  = 1'b1;
      pend_d  = 1'b0;
    end

    req_d  = (state_d == LD_REQ) || (state_d == ST_REQ);
    we_d   = (state_d == ST_REQ);
    addr_d = req_d ? cur_d : addr_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      end_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      pend_q   <= 1'b0;
      ld_err_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wcap_q   <= NULL_REG_CAP;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      pend_q   <= pend_d;
      ld_err_q <= ld_err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wcap_q   <= wcap_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign stat_busy_o      = busy_q;
  assign stat_done_o      = done_q;
  assign stat_err_o       = err_q;
  assign stat_clr_cnt_o   = cnt_q;
  assign tbre_lsu_req_o   = req_q;
  assign tbre_lsu_we_o    = we_q;
  assign tbre_lsu_addr_o  = addr_q;
  assign tbre_lsu_wdata_o = wdata_q;
  assign tbre_lsu_wcap_o  = wcap_q;

endmodule

// File: doc/cheri_tbre_sweep.md
CHERI_TBRE_SWEEP -- requirements
Module: cheri_tbre_sweep

Interface
REQ-001 SHALL have no parameters; capability granule is fixed at 8 bytes.
REQ-002 clk_i  input  1  clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 ctrl_start_i  input  1  one-cycle pulse, begin sweep.
REQ-005 ctrl_stop_i  input  1  one-cycle pulse, abort sweep.
REQ-006 ctrl_start_addr_i  input  32  first granule address; bits [2:0] ignored.
REQ-007 ctrl_end_addr_i  input  32  exclusive end address; bits [2:0] ignored.
REQ-008 stat_busy_o  output  1  high when state is not IDLE.
REQ-009 stat_done_o  output  1  one-cycle pulse on sweep completion or abort.
REQ-010 stat_err_o  output  1  sticky error; cleared on an accepted start.
REQ-011 stat_clr_cnt_o  output  16  tags cleared this sweep, saturating at 16'hFFFF.
REQ-012 tbre_lsu_req_o / tbre_lsu_we_o / tbre_lsu_addr_o  output  1/1/32  LSU request, write enable, address.
REQ-013 tbre_lsu_wdata_o  output  32; tbre_lsu_wcap_o  output  reg_cap_t  store payload.
REQ-014 lsu_tbre_gnt_i  input  1  request accepted this cycle.
REQ-015 lsu_tbre_resp_valid_i / lsu_tbre_resp_err_i / lsu_resp_is_wr_i  input  1/1/1  response, error, response-is-store.
REQ-016 lsu_rdata_i  input  32; lsu_rcap_i  input  reg_cap_t  loaded word and capability.
REQ-017 tbre_trvk_en_i / tbre_trvk_clrtag_i  input  1/1  revocation-check result for the last TBRE load.

Function
REQ-018 States SHALL be IDLE, LD_REQ, LD_WAIT, CHK_WAIT, ST_REQ, ST_WAIT, with a one-hot or encoded implementation.
REQ-019 IDLE + ctrl_start_i: latch cur_addr={start[31:3],3'b0} and end={end[31:3],3'b0}, clear err and count; go LD_REQ if cur<end, else pulse stat_done_o next cycle and stay IDLE.
REQ-020 ctrl_start_i outside IDLE SHALL be ignored.
REQ-021 LD_REQ: drive req=1, we=0, addr=cur_addr; hold all stable until lsu_tbre_gnt_i, then go LD_WAIT.
REQ-022 LD_WAIT: on resp_valid with is_wr=0, capture lsu_rdata_i and lsu_rcap_i, set err if resp_err, go CHK_WAIT.
REQ-023 CHK_WAIT: wait for tbre_trvk_en_i (expected 3 cycles after load response); timeout counter of 3 bits SHALL flag err and advance if not seen within 6 cycles.
REQ-024 On trvk_en with clrtag=1 and no load error: go ST_REQ; otherwise advance.
REQ-025 ST_REQ: req=1, we=1, addr=cur_addr, wdata=captured data, wcap=captured cap with valid=0; hold until gnt, go ST_WAIT.
REQ-026 ST_WAIT: on resp_valid with is_wr=1, set err if resp_err, else increment count (saturating); advance.
REQ-027 Advance: cur_addr+=8 (32-bit wrap); if new cur_addr>=end or add wrapped, pulse stat_done_o and go IDLE, else LD_REQ.
REQ-028 tbre_lsu_req_o SHALL be high only in LD_REQ/ST_REQ; at most one LSU transaction outstanding.
REQ-029 ctrl_stop_i in LD_REQ/ST_REQ before gnt, or in CHK_WAIT: go IDLE next cycle with stat_done_o pulse; a stop coinciding with gnt is treated as after gnt.
REQ-030 ctrl_stop_i in LD_WAIT/ST_WAIT: set pending-stop, finish the response, then go IDLE with stat_done_o instead of continuing; a store in flight still counts.
REQ-031 Simultaneous start and stop in IDLE: start wins, stop ignored.
REQ-032 Responses arriving in IDLE or with wrong is_wr SHALL be ignored.

Reset
REQ-033 On rst_ni low: state IDLE, req=0, we=0, addr=0, wdata=0, wcap=NULL_REG_CAP, busy=0, done=0, err=0, count=0, timeout=0, pending-stop=0; mid-sweep reset abandons the sweep with no done pulse.

Verification
REQ-034 start=0x1000, end=0x1018, no clrtag -> three loads at 0x1000/0x1008/0x1010, no stores, done pulse, count=0.
REQ-035 start=0x2000, end=0x2010, clrtag=1 on second granule -> store to 0x2008 with wcap.valid=0 and loaded data, count=1.
REQ-036 start=end=0x3000 -> no request, done next cycle, busy never high.
REQ-037 Load resp_err at 0x4000 -> err=1, no store even if clrtag=1, sweep continues to end.
REQ-038 Stop during LD_WAIT -> no new request after response, done pulse, IDLE; trvk_en withheld in CHK_WAIT -> err after 6 cycles.
REQ-039 gnt held low 5 cycles -> req/addr/we stable throughout; start=0xFFFFFFF8, end=0 -> one load, wrap ends sweep.
